// File: rtl/npm_toggle_timer_sequencer_pkg.sv
// Shared definitions for the NAND-primitive timer step sequencer.
package npm_toggle_timer_sequencer_pkg;

   localparam int OPT_CE  = 0;
   localparam int OPT_DQS = 1;
   localparam int OPT_SIG = 2;

   localparam int OptionWidth = 3;
   localparam int CountWidth  = 16;
   localparam int StepWidth   = OptionWidth + CountWidth;

   localparam int SeqStateWidth = 4;
   localparam logic [SeqStateWidth-1:0] ST_IDLE  = 4'b0001;
   localparam logic [SeqStateWidth-1:0] ST_ISSUE = 4'b0010;
   localparam logic [SeqStateWidth-1:0] ST_WAIT  = 4'b0100;
   localparam logic [SeqStateWidth-1:0] ST_DONE  = 4'b1000;

   typedef struct packed {
      logic [OptionWidth-1:0] option;
      logic [CountWidth-1:0]  num_of_data;
   } step_t;

   function automatic step_t make_step(input logic [OptionWidth-1:0] option,
                                       input logic [CountWidth-1:0] num_of_data);
      step_t s;
      s.option      = option;
      s.num_of_data = num_of_data;
      return s;
   endfunction

endpackage

// File: rtl/npm_toggle_timer_sequencer_if.sv
// Bundle between the dispatcher/timer side (master) and the step sequencer (slave).
interface npm_toggle_timer_sequencer_if #(
   parameter int NumberOfWays  = 4,
   parameter int StepAddrWidth = 3
);
   logic                     iStepWrite;
   logic [StepAddrWidth-1:0] iStepAddr;
   logic [2:0]               iStepOption;
   logic [15:0]              iStepNumOfData;
   logic                     iStart;
   logic [NumberOfWays-1:0]  iTargetWay;
   logic [StepAddrWidth-1:0] iLastStepIndex;
   logic                     oReady;
   logic                     oDone;
   logic [StepAddrWidth-1:0] oCurrentStep;
   logic                     oTimerStart;
   logic [2:0]               oTimerOption;
   logic [15:0]              oTimerNumOfData;
   logic [NumberOfWays-1:0]  oTimerTargetWay;
   logic                     iTimerReady;
   logic                     iTimerLastStep;

   modport master (
      output iStepWrite, iStepAddr, iStepOption, iStepNumOfData,
      output iStart, iTargetWay, iLastStepIndex,
      output iTimerReady, iTimerLastStep,
      input  oReady, oDone, oCurrentStep,
      input  oTimerStart, oTimerOption, oTimerNumOfData, oTimerTargetWay
   );

   modport slave (
      input  iStepWrite, iStepAddr, iStepOption, iStepNumOfData,
      input  iStart, iTargetWay, iLastStepIndex,
      input  iTimerReady, iTimerLastStep,
      output oReady, oDone, oCurrentStep,
      output oTimerStart, oTimerOption, oTimerNumOfData, oTimerTargetWay
   );
endinterface

// File: rtl/npm_toggle_timer_step_table.sv
// Step table: one write port, two combinational read ports (current and next step), no reset.
module npm_toggle_timer_step_table
   import npm_toggle_timer_sequencer_pkg::*;
#(
   parameter int StepAddrWidth = 3
) (
   input  logic                     clk,
   input  logic                     write_en,
   input  logic [StepAddrWidth-1:0] write_addr,
   input  step_t                    write_data,
   input  logic [StepAddrWidth-1:0] read_addr_a,
   output step_t                    read_data_a,
   input  logic [StepAddrWidth-1:0] read_addr_b,
   output step_t                    read_data_b
);
   step_t table_q [2**StepAddrWidth];

   // store a programmed step; contents deliberately survive reset
   always_ff @(posedge clk) begin
      if (write_en) table_q[write_addr] <= write_data;
   end

   assign read_data_a = table_q[read_addr_a];
   assign read_data_b = table_q[read_addr_b];

endmodule

// File: rtl/npm_toggle_timer_sequencer.sv
// Issues a programmed list of timer steps to the timer as one gap-free job.
module npm_toggle_timer_sequencer
   import npm_toggle_timer_sequencer_pkg::*;
#(
   parameter int NumberOfWays  = 4,
   parameter int StepAddrWidth = 3
) (
   input logic iSystemClock,
   input logic iReset,
   npm_toggle_timer_sequencer_if.slave bus
);
   logic [SeqStateWidth-1:0] state;
   logic [StepAddrWidth-1:0] step_index;
   logic [StepAddrWidth-1:0] last_index;
   logic [StepAddrWidth-1:0] next_index;
   logic [NumberOfWays-1:0]  target_way;
   logic                     table_write;
   logic                     chain;
   step_t                    write_step;
   step_t                    cur_step;
   step_t                    next_step;
   step_t                    issue_step;

   assign table_write = bus.iStepWrite && (state == ST_IDLE);
   assign write_step  = make_step(bus.iStepOption, bus.iStepNumOfData);
   assign next_index  = step_index + StepAddrWidth'(1);

   npm_toggle_timer_step_table #(
      .StepAddrWidth(StepAddrWidth)
   ) u_step_table (
      .clk        (iSystemClock),
      .write_en   (table_write),
      .write_addr (bus.iStepAddr),
      .write_data (write_step),
      .read_addr_a(step_index),
      .read_data_a(cur_step),
      .read_addr_b(next_index),
      .read_data_b(next_step)
   );

   // the timer flags its last cycle; when more steps remain, start the next one in that same cycle
   assign chain = (state == ST_WAIT) && bus.iTimerLastStep && (step_index != last_index);

   // select what the timer sees: next step while chaining, zeros while idle, current step otherwise
   always_comb begin
      issue_step = cur_step;
      if (state == ST_IDLE)
         issue_step = '0;
      else if (chain)
         issue_step = next_step;
   end

   // job sequencing: latch the job at start, walk the table on each last-step, pulse done at the end
   always_ff @(posedge iSystemClock) begin
      if (iReset) begin
         state      <= ST_IDLE;
         step_index <= '0;
         last_index <= '0;
         target_way <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.iStart) begin
                  target_way <= bus.iTargetWay;
                  last_index <= bus.iLastStepIndex;
                  step_index <= '0;
                  state      <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (bus.iTimerReady) state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (bus.iTimerLastStep) begin
                  if (step_index != last_index)
                     step_index <= next_index;
                  else
                     state <= ST_DONE;
               end
            end
            ST_DONE: begin
               state      <= ST_IDLE;
               step_index <= '0;
               target_way <= '0;
            end
            default: begin
               state      <= ST_IDLE;
               step_index <= '0;
               target_way <= '0;
            end
         endcase
      end
   end

   assign bus.oReady          = (state == ST_IDLE);
   assign bus.oDone           = (state == ST_DONE);
   assign bus.oCurrentStep    = step_index;
   assign bus.oTimerStart     = (state == ST_ISSUE) || chain;
   assign bus.oTimerOption    = issue_step.option;
   assign bus.oTimerNumOfData = issue_step.num_of_data;
   assign bus.oTimerTargetWay = target_way;

endmodule

// File: tb/tb_npm_toggle_timer_sequencer.sv
// Self-checking bench for npm_toggle_timer_sequencer with a behavioural timer on its output side.
module tb_npm_toggle_timer_sequencer;
   import npm_toggle_timer_sequencer_pkg::*;

   localparam int NumberOfWays  = 4;
   localparam int StepAddrWidth = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   npm_toggle_timer_sequencer_if #(
      .NumberOfWays (NumberOfWays),
      .StepAddrWidth(StepAddrWidth)
   ) bus ();

   npm_toggle_timer_sequencer #(
      .NumberOfWays (NumberOfWays),
      .StepAddrWidth(StepAddrWidth)
   ) dut (
      .iSystemClock(clk),
      .iReset      (rst),
      .bus         (bus)
   );

   // Timer model: a start accepted while ready loads count N; the step then
   // lasts N+1 cycles and flags last-step in its final cycle, where it is ready again.
   logic        tmrBusy;
   logic [15:0] tmrCnt;
   logic        holdReady;

   assign bus.iTimerLastStep = tmrBusy && (tmrCnt == 16'd0);
   assign bus.iTimerReady    = (!tmrBusy || bus.iTimerLastStep) && !holdReady;

   always @(posedge clk) begin
      if (rst) begin
         tmrBusy <= 1'b0;
         tmrCnt  <= 16'd0;
      end else if (bus.oTimerStart && bus.iTimerReady) begin
         tmrBusy <= 1'b1;
         tmrCnt  <= bus.oTimerNumOfData;
      end else if (tmrBusy) begin
         if (tmrCnt == 16'd0) tmrBusy <= 1'b0;
         else                 tmrCnt  <= tmrCnt - 16'd1;
      end
   end

   int checkCnt = 0;
   int passCnt  = 0;

   // results of the most recent job run
   int          acceptCyc[$];
   logic [2:0]  accOpt[$];
   logic [15:0] accCnt[$];
   int          curAfter[$];
   int          startHigh, doneCyc, doneCnt, readyCyc, wayErr;
   logic [3:0]  wayAtReady;
   logic        startAtReady;
   logic [2:0]  curAtReady;

   typedef struct packed {
      int              nSteps;
      logic [3:0]      way;
      int              expDone;
      logic [3:0][2:0] opt;
      logic [3:0][15:0] cnt;
      logic [3:0][7:0] expStart;
   } jobVec_t;

   jobVec_t vecs [5];

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checkCnt++;
      if (actual == expected) passCnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   function automatic int qInt(input int idx);
      return (acceptCyc.size() > idx) ? acceptCyc[idx] : -1;
   endfunction

   function automatic int qOpt(input int idx);
      return (accOpt.size() > idx) ? int'(accOpt[idx]) : -1;
   endfunction

   function automatic int qCnt(input int idx);
      return (accCnt.size() > idx) ? int'(accCnt[idx]) : -1;
   endfunction

   function automatic int qCur(input int idx);
      return (curAfter.size() > idx) ? curAfter[idx] : -1;
   endfunction

   // called just after a rising edge; the write lands on the next edge
   task automatic writeStep(input logic [2:0] addr, input logic [2:0] opt, input logic [15:0] cnt);
      bus.iStepWrite     = 1'b1;
      bus.iStepAddr      = addr;
      bus.iStepOption    = opt;
      bus.iStepNumOfData = cnt;
      @(posedge clk); #1;
      bus.iStepWrite     = 1'b0;
   endtask

   // Runs one job with iStart in cycle 0 and records what the timer saw.
   // Optional disturbances: timer not ready through cycle holdCyc, an extra iStart,
   // a table write, or a reset in a given cycle (-1 disables each).
   task automatic applyStimulus(input logic [2:0] lastIdx, input logic [3:0] way, input int holdCyc,
                                input int injStartCyc, input int injWriteCyc, input logic [2:0] wAddr,
                                input logic [2:0] wOpt, input logic [15:0] wCnt, input int resetCyc);
      int c;
      bit prevAcc;
      acceptCyc.delete(); accOpt.delete(); accCnt.delete(); curAfter.delete();
      startHigh = 0; doneCyc = -1; doneCnt = 0; readyCyc = -1; wayErr = 0;
      wayAtReady = 4'hx; startAtReady = 1'bx; curAtReady = 3'hx;
      prevAcc = 1'b0;
      c = 0;
      bus.iStart         = 1'b1;
      bus.iTargetWay     = way;
      bus.iLastStepIndex = lastIdx;
      holdReady          = (holdCyc > 0);
      bus.iStepWrite     = (injWriteCyc == 0);
      bus.iStepAddr      = wAddr;
      bus.iStepOption    = wOpt;
      bus.iStepNumOfData = wCnt;
      while (c < 200 && (readyCyc < 0 || c < readyCyc + 3)) begin
         @(posedge clk); #1;
         c++;
         bus.iStart         = (c == injStartCyc);
         bus.iTargetWay     = ~way;
         bus.iLastStepIndex = ~lastIdx;
         holdReady          = (c <= holdCyc);
         bus.iStepWrite     = (c == injWriteCyc);
         rst                = (c == resetCyc);
         @(negedge clk);
         if (prevAcc) curAfter.push_back(int'(bus.oCurrentStep));
         prevAcc = bus.oTimerStart && bus.iTimerReady;
         if (prevAcc) begin
            acceptCyc.push_back(c);
            accOpt.push_back(bus.oTimerOption);
            accCnt.push_back(bus.oTimerNumOfData);
         end
         if (bus.oTimerStart) startHigh++;
         if (bus.oDone) begin
            doneCnt++;
            if (doneCyc < 0) doneCyc = c;
         end
         if (readyCyc < 0 && bus.oReady) begin
            readyCyc     = c;
            wayAtReady   = bus.oTimerTargetWay;
            startAtReady = bus.oTimerStart;
            curAtReady   = bus.oCurrentStep;
         end else if (readyCyc < 0 && (resetCyc < 0 || c <= resetCyc) && bus.oTimerTargetWay != way) begin
            wayErr++;
         end
      end
      @(posedge clk); #1;
      bus.iStart = 1'b0; bus.iStepWrite = 1'b0; holdReady = 1'b0; rst = 1'b0;
   endtask

   task automatic addStep(input int v, input int k, input logic [2:0] opt, input logic [15:0] cnt, input int st);
      vecs[v].opt[k]      = opt;
      vecs[v].cnt[k]      = cnt;
      vecs[v].expStart[k] = 8'(st);
   endtask

   initial begin
      // hand-computed: done cycle = 2 + sum(Ni+1); chained starts land on the previous step's last cycle
      vecs[0] = '0; vecs[0].nSteps = 1; vecs[0].way = 4'b0010; vecs[0].expDone = 7;
      addStep(0, 0, 3'b001, 16'd4, 1);
      vecs[1] = '0; vecs[1].nSteps = 3; vecs[1].way = 4'b0100; vecs[1].expDone = 10;
      addStep(1, 0, 3'b101, 16'd2, 1); addStep(1, 1, 3'b001, 16'd0, 4); addStep(1, 2, 3'b011, 16'd3, 5);
      vecs[2] = '0; vecs[2].nSteps = 1; vecs[2].way = 4'b1111; vecs[2].expDone = 3;
      addStep(2, 0, 3'b110, 16'd0, 1);
      vecs[3] = '0; vecs[3].nSteps = 2; vecs[3].way = 4'b1000; vecs[3].expDone = 4;
      addStep(3, 0, 3'b010, 16'd0, 1); addStep(3, 1, 3'b100, 16'd0, 2);
      vecs[4] = '0; vecs[4].nSteps = 4; vecs[4].way = 4'b0101; vecs[4].expDone = 14;
      addStep(4, 0, 3'b111, 16'd1, 1); addStep(4, 1, 3'b001, 16'd2, 3);
      addStep(4, 2, 3'b100, 16'd0, 6); addStep(4, 3, 3'b011, 16'd5, 7);

      rst = 1'b1; holdReady = 1'b0;
      bus.iStepWrite = 1'b0; bus.iStepAddr = '0; bus.iStepOption = '0; bus.iStepNumOfData = '0;
      bus.iStart = 1'b0; bus.iTargetWay = '0; bus.iLastStepIndex = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_ready",   bus.oReady, 1);
      checkOutput("reset_done",    bus.oDone, 0);
      checkOutput("reset_start",   bus.oTimerStart, 0);
      checkOutput("reset_step",    bus.oCurrentStep, 0);
      checkOutput("reset_way",     bus.oTimerTargetWay, 0);
      checkOutput("reset_option",  bus.oTimerOption, 0);
      checkOutput("reset_count",   bus.oTimerNumOfData, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] table-driven jobs");
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < vecs[v].nSteps; k++) writeStep(3'(k), vecs[v].opt[k], vecs[v].cnt[k]);
         applyStimulus(3'(vecs[v].nSteps - 1), vecs[v].way, 0, -1, -1, 3'd0, 3'd0, 16'd0, -1);
         checkOutput($sformatf("v%0d_done_cycle", v), doneCyc, vecs[v].expDone);
         checkOutput($sformatf("v%0d_done_pulses", v), doneCnt, 1);
         checkOutput($sformatf("v%0d_ready_back", v), readyCyc, vecs[v].expDone + 1);
         checkOutput($sformatf("v%0d_start_cycles", v), startHigh, vecs[v].nSteps);
         checkOutput($sformatf("v%0d_accepts", v), acceptCyc.size(), vecs[v].nSteps);
         checkOutput($sformatf("v%0d_way_held", v), wayErr, 0);
         checkOutput($sformatf("v%0d_way_cleared", v), wayAtReady, 0);
         for (int k = 0; k < vecs[v].nSteps; k++) begin
            checkOutput($sformatf("v%0d_s%0d_start", v, k), qInt(k), vecs[v].expStart[k]);
            checkOutput($sformatf("v%0d_s%0d_opt", v, k), qOpt(k), vecs[v].opt[k]);
            checkOutput($sformatf("v%0d_s%0d_cnt", v, k), qCnt(k), vecs[v].cnt[k]);
            checkOutput($sformatf("v%0d_s%0d_cur", v, k), qCur(k), k);
         end
      end

      $display("[TB] timer busy at start");
      writeStep(3'd0, 3'b011, 16'd2);
      applyStimulus(3'd0, 4'b0011, 3, -1, -1, 3'd0, 3'd0, 16'd0, -1);
      checkOutput("busy_start_cycles", startHigh, 4);
      checkOutput("busy_accepts", acceptCyc.size(), 1);
      checkOutput("busy_accept_cycle", qInt(0), 4);
      checkOutput("busy_done_cycle", doneCyc, 8);
      checkOutput("busy_done_pulses", doneCnt, 1);

      $display("[TB] write while busy");
      writeStep(3'd0, 3'b101, 16'd2);
      writeStep(3'd1, 3'b001, 16'd0);
      writeStep(3'd2, 3'b011, 16'd3);
      applyStimulus(3'd2, 4'b0110, 0, -1, 2, 3'd1, 3'b111, 16'd9, -1);
      checkOutput("wbusy_s1_opt", qOpt(1), 3'b001);
      checkOutput("wbusy_s1_cnt", qCnt(1), 0);
      checkOutput("wbusy_done_cycle", doneCyc, 10);
      applyStimulus(3'd1, 4'b0110, 0, -1, -1, 3'd0, 3'd0, 16'd0, -1);
      checkOutput("wdropped_s1_cnt", qCnt(1), 0);
      checkOutput("wdropped_done_cycle", doneCyc, 6);

      $display("[TB] write and start together");
      applyStimulus(3'd1, 4'b0001, 0, -1, 0, 3'd1, 3'b111, 16'd9, -1);
      checkOutput("wstart_s1_opt", qOpt(1), 3'b111);
      checkOutput("wstart_s1_cnt", qCnt(1), 9);
      checkOutput("wstart_s1_start", qInt(1), 4);
      checkOutput("wstart_done_cycle", doneCyc, 15);

      $display("[TB] reset during step 1");
      applyStimulus(3'd2, 4'b1010, 0, -1, -1, 3'd0, 3'd0, 16'd0, 6);
      checkOutput("rst_ready_cycle", readyCyc, 7);
      checkOutput("rst_start_low", startAtReady, 0);
      checkOutput("rst_way_zero", wayAtReady, 0);
      checkOutput("rst_step_zero", curAtReady, 0);
      checkOutput("rst_no_done", doneCnt, 0);
      checkOutput("rst_way_held", wayErr, 0);

      $display("[TB] start while busy");
      applyStimulus(3'd2, 4'b1100, 0, 6, -1, 3'd0, 3'd0, 16'd0, -1);
      checkOutput("sbusy_done_cycle", doneCyc, 19);
      checkOutput("sbusy_done_pulses", doneCnt, 1);
      checkOutput("sbusy_accepts", acceptCyc.size(), 3);
      checkOutput("sbusy_start_cycles", startHigh, 3);
      checkOutput("sbusy_way_held", wayErr, 0);

      $display("[TB] full table, one pass");
      for (int k = 0; k < 8; k++) writeStep(3'(k), 3'(k), 16'd0);
      applyStimulus(3'd7, 4'b1111, 0, -1, -1, 3'd0, 3'd0, 16'd0, -1);
      checkOutput("full_accepts", acceptCyc.size(), 8);
      checkOutput("full_last_start", qInt(7), 8);
      checkOutput("full_last_opt", qOpt(7), 7);
      checkOutput("full_last_cur", qCur(7), 7);
      checkOutput("full_done_cycle", doneCyc, 10);
      checkOutput("full_done_pulses", doneCnt, 1);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule
